key_filter_multi: RTL
=====================

# key_filter_multi

Parametrised multi-channel key debouncer for front-panel push-buttons. Each channel has its own synchroniser, debounce state machine, long-press detector and auto-repeat generator. Each channel produces a debounced level plus single-cycle press, release, long-press and repeat strobes. It replaces per-key single-channel filters in the control path and feeds mode/frequency-select logic directly.

## Interface
- `N_KEYS`, default 4: number of independent key channels (≥1).
- `DEBOUNCE_CYC`, default 800_000: cycles a new level must hold before acceptance (≥2).
- `LONG_CYC`, default 50_000_000: cycles held after the press is confirmed before `long_flag` fires (≥1).
- `REPEAT_CYC`, default 10_000_000: auto-repeat period after a long press (0 disables repeat).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key_in` in N_KEYS: raw key pins, active-low (0 = pressed), asynchronous to `clk`.
- `key_level` out N_KEYS: debounced state, 1 = pressed.
- `press_flag` out N_KEYS: 1-cycle pulse on a confirmed press.
- `release_flag` out N_KEYS: 1-cycle pulse on a confirmed release.
- `long_flag` out N_KEYS: 1-cycle pulse, once per press, after `LONG_CYC` held cycles.
- `rpt_flag` out N_KEYS: 1-cycle pulse every `REPEAT_CYC` cycles while held after `long_flag`.

## Operation
- Per channel, a 2-flop synchroniser `s1`→`s2` resets to 1 (released). All filter decisions use `s2`.
- The debounce counter `dcnt` is $clog2(DEBOUNCE_CYC) bits wide.
- The hold counter `hcnt` is $clog2(max(LONG_CYC,REPEAT_CYC)+1) bits wide.
- Both counters saturate and never wrap.
- Per-channel states:
  - IDLE (`key_level`=0): if `s2`=0, go to PRESS_FILT with `dcnt`=0.
  - PRESS_FILT: if `s2`=1 (bounce), go to IDLE, clear `dcnt`, no flag. Else, if `dcnt`=DEBOUNCE_CYC-1, go to HELD, pulse `press_flag`, set `key_level`=1, clear `dcnt` and `hcnt`. Otherwise increment `dcnt`.
  - HELD (`key_level`=1): `hcnt` increments each cycle. If `s2`=1, go to RELEASE_FILT with `dcnt`=0.
  - RELEASE_FILT: if `s2`=0 (bounce), return to HELD; `hcnt` resumes from its held value. Else, if `dcnt`=DEBOUNCE_CYC-1, go to IDLE, pulse `release_flag`, set `key_level`=0, clear `dcnt` and `hcnt`. Otherwise increment `dcnt`. `hcnt` is frozen in this state.
- Long press: in HELD, when `hcnt` reaches LONG_CYC-1 for the first time in this press, pulse `long_flag`.
- Repeat (REPEAT_CYC>0): after `long_flag`, `hcnt` restarts at 0. Each time it reaches REPEAT_CYC-1, pulse `rpt_flag` and restart.
- REPEAT_CYC=0: `hcnt` saturates after `long_flag`; `rpt_flag` stays 0.
- `long_flag` and `rpt_flag` never fire outside HELD.
- `key_level` stays 1 throughout RELEASE_FILT.
- Channels are fully independent. Simultaneous events on different channels produce their strobes in the same cycle.
- Illegal or unused state encodings go to IDLE with counters cleared.

## Timing
- Reset (async assert, sync-safe release):
  - all outputs 0;
  - all states IDLE;
  - counters 0;
  - `s1`/`s2` = 1.
- Assertion mid-press aborts immediately and emits no release strobe.
- Press latency: `key_in` sampled low at edge 1 and held gives `press_flag` high in the cycle after edge DEBOUNCE_CYC+3.
- Release latency: identical, DEBOUNCE_CYC+3 edges from the first low→high sample.
- `long_flag` fires LONG_CYC cycles after `press_flag`, provided no RELEASE_FILT excursion occurred.
- Each RELEASE_FILT excursion delays `long_flag` by the number of cycles spent in RELEASE_FILT.
- `rpt_flag` spacing is exactly REPEAT_CYC cycles, with the first one REPEAT_CYC cycles after `long_flag`.
- All strobes last exactly one cycle. `key_level` changes in the same cycle as the corresponding press/release strobe.
- A key held low through reset release is reported as a press DEBOUNCE_CYC+3 cycles after release.

## Test plan
Bench parameters: N_KEYS=2, DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3.
- Clean press on key0 (low from edge 1): `press_flag[0]` pulses after edge 7; `key_level[0]`=1 from then; key1 outputs stay 0.
- Bounce: key0 low for 3 cycles, high for 2, then low and held. No strobe for the bounce; one `press_flag[0]` DEBOUNCE_CYC+3 after the final low sample.
- Long + repeat on key0:
  - `long_flag[0]` fires 10 cycles after `press_flag[0]`;
  - `rpt_flag[0]` fires at +3, +6 and +9 after it;
  - on release, `release_flag[0]` fires 7 cycles after the release sample and repeats stop.
- Release glitch: during HELD, key0 goes high for 2 cycles. No `release_flag`; `key_level` stays 1; `long_flag` is delayed by 2 cycles.
- Simultaneous: both keys pressed at the same edge → `press_flag`=2'b11 in one cycle. Then key1 alone is released → only `release_flag[1]`.
- Reset mid-press: assert `rst` during PRESS_FILT and during HELD. All outputs are 0 immediately, with no release strobe. After deassertion with the key still low, press is re-detected 7 cycles later.

Source files
------------

// File: rtl/key_filter_multi.sv
// key_filter_multi: N independent push-button channels, each with a 2-flop
// synchroniser, debounce FSM, long-press detector and auto-repeat generator.
module key_filter_multi #(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 800_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_flag,
  output logic [N_KEYS-1:0] release_flag,
  output logic [N_KEYS-1:0] long_flag,
  output logic [N_KEYS-1:0] rpt_flag
);

  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int DCNT_W   = $clog2(DEBOUNCE_CYC);
  localparam int HCNT_W   = $clog2(HOLD_MAX + 1);
  localparam bit RPT_EN   = (REPEAT_CYC > 0);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_CYC - 1);
  localparam logic [HCNT_W-1:0] RPT_LAST  = HCNT_W'(RPT_EN ? REPEAT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_FILT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_FILT = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
      logic              r_s1;
      logic              r_s2;
      state_t            r_state;
      state_t            w_state_next;
      logic [DCNT_W-1:0] r_dcnt;
      logic [DCNT_W-1:0] w_dcnt_next;
      logic [DCNT_W-1:0] w_dcnt_inc;
      logic [HCNT_W-1:0] r_hcnt;
      logic [HCNT_W-1:0] w_hcnt_next;
      logic [HCNT_W-1:0] w_hcnt_inc;
      logic              r_long_done;
      logic              w_long_done_next;
      logic              r_level;
      logic              w_level_next;
      logic              r_press;
      logic              w_press_next;
      logic              r_release;
      logic              w_release_next;
      logic              r_long;
      logic              w_long_next;
      logic              r_rpt;
      logic              w_rpt_next;

      // Synchroniser idles at 1 so a reset never looks like a pressed key.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1 <= 1'b1;
          r_s2 <= 1'b1;
        end else begin
          r_s1 <= key_in[gi];
          r_s2 <= r_s1;
        end
      end

      assign w_dcnt_inc = (r_dcnt == {DCNT_W{1'b1}}) ? r_dcnt : r_dcnt + DCNT_W'(1);
      assign w_hcnt_inc = (r_hcnt == {HCNT_W{1'b1}}) ? r_hcnt : r_hcnt + HCNT_W'(1);

      always_comb begin
        w_state_next     = r_state;
        w_dcnt_next      = r_dcnt;
        w_hcnt_next      = r_hcnt;
        w_long_done_next = r_long_done;
        w_level_next     = r_level;
        w_press_next     = 1'b0;
        w_release_next   = 1'b0;
        w_long_next      = 1'b0;
        w_rpt_next       = 1'b0;

        case (r_state)
          ST_IDLE: begin
            w_level_next     = 1'b0;
            w_dcnt_next      = '0;
            w_hcnt_next      = '0;
            w_long_done_next = 1'b0;
            if (!r_s2) begin
              w_state_next = ST_PRESS_FILT;
            end
          end

          ST_PRESS_FILT: begin
            if (r_s2) begin
              w_state_next = ST_IDLE;
              w_dcnt_next  = '0;
            end else if (r_dcnt == DCNT_LAST) begin
              w_state_next     = ST_HELD;
              w_press_next     = 1'b1;
              w_level_next     = 1'b1;
              w_dcnt_next      = '0;
              w_hcnt_next      = '0;
              w_long_done_next = 1'b0;
            end else begin
              w_dcnt_next = w_dcnt_inc;
            end
          end

          ST_HELD: begin
            w_level_next = 1'b1;
            // Hold timing: first LONG_CYC cycles end in long_flag, then hcnt
            // is reused as the repeat period counter (or saturates if disabled).
            if (!r_long_done && (r_hcnt == LONG_LAST)) begin
              w_long_next      = 1'b1;
              w_long_done_next = 1'b1;
              w_hcnt_next      = RPT_EN ? '0 : w_hcnt_inc;
            end else if (RPT_EN && r_long_done && (r_hcnt == RPT_LAST)) begin
              w_rpt_next  = 1'b1;
              w_hcnt_next = '0;
            end else begin
              w_hcnt_next = w_hcnt_inc;
            end
            if (r_s2) begin
              w_state_next = ST_RELEASE_FILT;
              w_dcnt_next  = '0;
            end
          end

          ST_RELEASE_FILT: begin
            // hcnt is frozen here so a release glitch only delays long/repeat.
            w_level_next = 1'b1;
            if (!r_s2) begin
              w_state_next = ST_HELD;
              w_dcnt_next  = '0;
            end else if (r_dcnt == DCNT_LAST) begin
              w_state_next     = ST_IDLE;
              w_release_next   = 1'b1;
              w_level_next     = 1'b0;
              w_dcnt_next      = '0;
              w_hcnt_next      = '0;
              w_long_done_next = 1'b0;
            end else begin
              w_dcnt_next = w_dcnt_inc;
            end
          end

          default: begin
            w_state_next     = ST_IDLE;
            w_level_next     = 1'b0;
            w_dcnt_next      = '0;
            w_hcnt_next      = '0;
            w_long_done_next = 1'b0;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state     <= ST_IDLE;
          r_dcnt      <= '0;
          r_hcnt      <= '0;
          r_long_done <= 1'b0;
          r_level     <= 1'b0;
          r_press     <= 1'b0;
          r_release   <= 1'b0;
          r_long      <= 1'b0;
          r_rpt       <= 1'b0;
        end else begin
          r_state     <= w_state_next;
          r_dcnt      <= w_dcnt_next;
          r_hcnt      <= w_hcnt_next;
          r_long_done <= w_long_done_next;
          r_level     <= w_level_next;
          r_press     <= w_press_next;
          r_release   <= w_release_next;
          r_long      <= w_long_next;
          r_rpt       <= w_rpt_next;
        end
      end

      assign key_level[gi]    = r_level;
      assign press_flag[gi]   = r_press;
      assign release_flag[gi] = r_release;
      assign long_flag[gi]    = r_long;
      assign rpt_flag[gi]     = r_rpt;
    end
  endgenerate

endmodule
